// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit D flip-flop register among N_REQ write requesters.
// A granted owner writes once, or up to MAX_HOLD times while it holds lock.
module dff_reg_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_i,
   input  logic [N_REQ-1:0]           lock_i,
   input  logic [N_REQ*WIDTH-1:0]     wr_data_i,
   output logic [N_REQ-1:0]           gnt_o,
   output logic [N_REQ-1:0]           ack_o,
   output logic [WIDTH-1:0]           q_o,
   output logic [WIDTH-1:0]           qbar_o,
   output logic                       busy_o,
   output logic [$clog2(N_REQ)-1:0]   owner_o
);

   localparam int unsigned IDX_W = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   qbar_q, qbar_d;
   logic               busy_q, busy_d;

   logic               sel_vld;
   logic [IDX_W-1:0]   sel;
   logic [WIDTH-1:0]   wr_sel;
   logic [IDX_W-1:0]   ptr_nxt;
   logic               last_wr;

   // First requester at or after the round-robin pointer, wrapping mod N_REQ.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      sel_vld = 1'b0;
      sel     = ptr_q;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!sel_vld && req_i[IDX_W'(idx)]) begin
            sel_vld = 1'b1;
            sel     = IDX_W'(idx);
         end
      end
   end

   // Owner's write-data slice.
   always_comb begin
      wr_sel = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (owner_q == IDX_W'(i)) wr_sel = wr_data_i[i*WIDTH +: WIDTH];
      end
   end

   assign ptr_nxt = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign last_wr = (cnt_q == CNT_W'(MAX_HOLD - 1));

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      q_d     = q_q;
      qbar_d  = qbar_q;

      case (state_q)
         IDLE: begin
            if (sel_vld) begin
               state_d = OWN;
               gnt_d   = N_REQ'(1) << sel;
               owner_d = sel;
               cnt_d   = '0;
            end
         end
         OWN: begin
            if (!req_i[owner_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = ptr_nxt;
            end else begin
               q_d            = wr_sel;
               qbar_d         = ~wr_sel;
               ack_d[owner_q] = 1'b1;
               cnt_d          = cnt_q + 1'b1;
               // Burst ends when lock drops or the tenure cap is reached.
               if (!lock_i[owner_q] || last_wr) begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  ptr_d   = ptr_nxt;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == OWN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         q_q     <= '0;
         qbar_q  <= '1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         qbar_q  <= qbar_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt_o   = gnt_q;
   assign ack_o   = ack_q;
   assign q_o     = q_q;
   assign qbar_o  = qbar_q;
   assign busy_o  = busy_q;
   assign owner_o = owner_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed self-checking bench for dff_reg_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
module tb_dff_reg_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [31:0] wr_data;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [7:0]  q;
   logic [7:0]  qbar;
   logic        busy;
   logic [1:0]  owner;

   int errors = 0;
   int checks = 0;

   dff_reg_arbiter #(
      .N_REQ   (4),
      .WIDTH   (8),
      .MAX_HOLD(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .lock_i    (lock),
      .wr_data_i (wr_data),
      .gnt_o     (gnt),
      .ack_o     (ack),
      .q_o       (q),
      .qbar_o    (qbar),
      .busy_o    (busy),
      .owner_o   (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b1;
      req     = '0;
      lock    = '0;
      wr_data = '0;

      // Asynchronous reset before any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_q",     32'(q),    32'h00);
      chk("rst_qbar",  32'(qbar), 32'hFF);
      chk("rst_gnt",   32'(gnt),  32'h0);
      chk("rst_ack",   32'(ack),  32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_owner", 32'(owner),32'h0);
      step();
      rst_n = 1'b1;

      // Single write by requester 1.
      req     = 4'b0010;
      wr_data = 32'h0000A500;
      step();
      chk("sw_gnt",   32'(gnt),   32'h2);
      chk("sw_busy",  32'(busy),  32'h1);
      chk("sw_owner", 32'(owner), 32'h1);
      chk("sw_q_pre", 32'(q),     32'h00);
      step();
      chk("sw_q",     32'(q),    32'hA5);
      chk("sw_qbar",  32'(qbar), 32'h5A);
      chk("sw_ack",   32'(ack),  32'h2);
      chk("sw_gnt0",  32'(gnt),  32'h0);
      chk("sw_busy0", 32'(busy), 32'h0);
      req = '0;
      step();
      chk("sw_ack0",  32'(ack),  32'h0);
      chk("sw_hold",  32'(q),    32'hA5);

      // Round robin with all four requesting.
      do_reset();
      req     = 4'b1111;
      wr_data = 32'h13121110;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_gnt",   32'(gnt),   32'(4'b0001 << (i % 4)));
         chk("rr_owner", 32'(owner), 32'(i % 4));
         chk("rr_ack0",  32'(ack),   32'h0);
         step();
         chk("rr_q",     32'(q),     32'h10 + 32'(i % 4));
         chk("rr_ack",   32'(ack),   32'(4'b0001 << (i % 4)));
         chk("rr_idle",  32'(gnt),   32'h0);
      end
      req = '0;

      // Locked burst capped at four writes, then requester 3 before 2.
      do_reset();
      req     = 4'b1100;
      lock    = 4'b0100;
      wr_data = 32'h33010000;
      step();
      chk("bc_gnt",  32'(gnt),  32'h4);
      chk("bc_busy", 32'(busy), 32'h1);
      for (int w = 1; w <= 4; w++) begin
         step();
         chk("bc_q",   32'(q),   32'(w));
         chk("bc_ack", 32'(ack), 32'h4);
         chk("bc_gnt_w", 32'(gnt), (w < 4) ? 32'h4 : 32'h0);
         wr_data = {8'h33, 8'(w + 1), 16'h0000};
      end
      step();
      chk("bc_next_gnt", 32'(gnt), 32'h8);
      chk("bc_ack_end",  32'(ack), 32'h0);
      chk("bc_q_hold",   32'(q),   32'h04);
      step();
      chk("bc_q3",   32'(q),   32'h33);
      chk("bc_ack3", 32'(ack), 32'h8);
      chk("bc_rel3", 32'(gnt), 32'h0);
      step();
      chk("bc_regnt2", 32'(gnt), 32'h4);
      req = '0;
      step();
      chk("bc_drop_gnt", 32'(gnt), 32'h0);
      chk("bc_drop_ack", 32'(ack), 32'h0);
      chk("bc_drop_q",   32'(q),   32'h33);
      lock = '0;

      // Withdrawal before the write edge.
      do_reset();
      req     = 4'b0001;
      wr_data = 32'h0000005C;
      step();
      step();
      chk("wd_q_first", 32'(q), 32'h5C);
      step();
      chk("wd_gnt", 32'(gnt), 32'h1);
      wr_data = 32'h000000EE;
      req     = '0;
      step();
      chk("wd_q",    32'(q),    32'h5C);
      chk("wd_ack",  32'(ack),  32'h0);
      chk("wd_gnt0", 32'(gnt),  32'h0);
      chk("wd_busy", 32'(busy), 32'h0);

      // Reset in the middle of a locked burst.
      do_reset();
      req     = 4'b0010;
      lock    = 4'b0010;
      wr_data = 32'h00002100;
      step();
      chk("mr_gnt", 32'(gnt), 32'h2);
      step();
      chk("mr_q1", 32'(q), 32'h21);
      wr_data = 32'h00002200;
      step();
      chk("mr_q2",   32'(q),   32'h22);
      chk("mr_ack2", 32'(ack), 32'h2);
      chk("mr_gnt2", 32'(gnt), 32'h2);
      req = 4'b0011;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_rst_q",    32'(q),    32'h00);
      chk("mr_rst_qbar", 32'(qbar), 32'hFF);
      chk("mr_rst_gnt",  32'(gnt),  32'h0);
      chk("mr_rst_ack",  32'(ack),  32'h0);
      chk("mr_rst_busy", 32'(busy), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("mr_after_gnt",   32'(gnt),   32'h1);
      chk("mr_after_owner", 32'(owner), 32'h0);
      req  = '0;
      lock = '0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dff_reg_arbiter.md
Name: dff_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit register, built from D flip-flops, among N_REQ write requesters.
- Grants one owner at a time, loads that owner's data into the register, and returns a one-cycle ack per completed write.
- An owner holding lock may burst up to MAX_HOLD writes in one tenure.
- Sits between requester logic and the shared storage register; q/qbar feed downstream consumers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, register width in bits.
- MAX_HOLD, 4, maximum writes per tenure when lock is held (>=1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester write request.
- lock  input  N_REQ  per-requester burst request; sampled only while that requester owns the register.
- wr_data  input  N_REQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  one-hot grant, registered; all zero when idle.
- ack  output  N_REQ  one-cycle pulse, registered; set in the cycle after each completed write.
- q  output  WIDTH  shared register contents.
- qbar  output  WIDTH  bitwise complement of q; always equals ~q.
- busy  output  1  high while in OWN.
- owner  output  clog2(N_REQ)  index of the current or most recent owner.

Behaviour:
- Reset (rst_n low, asynchronous) takes effect immediately and outranks everything, including an in-progress burst:
  - state=IDLE; q=0; qbar=all ones; gnt=0; ack=0; busy=0; owner=0; rr pointer ptr=0; hold count cnt=0.
  - No partial write completes.
- State IDLE:
  - If any req bit is set, select the first set index scanning ptr, ptr+1, ... with wrap mod N_REQ.
  - At the next edge: gnt = one-hot(sel), owner = sel, cnt = 0, state = OWN.
  - If no req bit is set, remain in IDLE.
  - req changes in other bits have no effect once the selection edge has passed.
- State OWN (owner o), evaluated each edge:
  - req[o]=0: release with no write. gnt=0, state=IDLE, ptr=(o+1) mod N_REQ.
  - req[o]=1: write. q <= wr_data slice o; ack[o]=1 in the following cycle; cnt <= cnt+1.
  - Release occurs at that same write edge if lock[o]=0, or if cnt+1 == MAX_HOLD. On release: gnt=0, state=IDLE, ptr=(o+1) mod N_REQ.
  - Otherwise stay in OWN and write again at the next edge.
- Latency:
  - req rises before edge E0 while IDLE → gnt high after E0 → write at E1 → q updated and ack high after E1.
  - Minimum turnaround between tenures is one IDLE cycle, so at most one tenure starts every two cycles.
- ack is high for exactly one cycle per write and only on the owner's bit. Non-owner ack bits are always 0.
- A released owner that still requests is re-served only after all other pending requesters (pointer moved past it).
- Pointer wraps from N_REQ-1 to 0.
- req/lock/wr_data of non-owners are ignored in OWN.
- q holds its value whenever no write occurs, including in IDLE.
- busy = (state == OWN).
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: drive rst_n=0 mid-cycle, with no clock edge → q=0x00, qbar=0xFF, gnt=0, ack=0, busy=0 immediately.
- Single write: req=4'b0010, lock=0, wr_data slice1=0xA5.
  - gnt=0010 one cycle after req.
  - Next edge: q=0xA5, qbar=0x5A, ack=0010 for one cycle.
  - Then gnt=0, busy=0.
- Round robin: req=4'b1111 held, lock=0, slice i = 0x10+i.
  - Grant order 0,1,2,3,0.
  - q sequence 0x10,0x11,0x12,0x13,0x10.
  - One IDLE cycle between each grant.
- Burst cap: req[2]=1, lock[2]=1 held 6 cycles, slice2 incrementing 0x01.. each cycle.
  - Exactly 4 writes: q ends 0x04, four ack[2] pulses.
  - Then release; next grant goes to requester 3 (if requesting) before 2.
- Withdrawal: requester 0 granted, req[0] dropped before its write edge → no write, q unchanged, no ack, gnt cleared next edge.
- Reset mid-burst: requester 1 locked after 2 writes (q=0x22), assert rst_n=0 → q=0x00, gnt=0 immediately.
  - After release, requester 0 is served first (ptr=0).
